// File: rtl/axis_bram_reader_pkg.sv
// axis_bram_reader_pkg: shared types and constants for the AXI-Stream BRAM reader.
// Build option: define AXIS_BRAM_READER_OUTREG_EN when the BRAM output register
// is enabled (read latency 2); otherwise the read latency is 1.
package axis_bram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef AXIS_BRAM_READER_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/axis_bram_reader_fifo.sv
// axis_bram_reader_fifo: small synchronous FIFO whose head entry, valid flag and
// occupancy are all held in flops, so the stream outputs come straight from registers.
module axis_bram_reader_fifo
    import axis_bram_reader_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  valid_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic [FIFO_CNT_W-1:0] occ_after_pop_s;
    logic [WIDTH-1:0]      head_q, head_d;
    logic                  valid_q, valid_d;
    logic                  pop_s, push_s;

    // Next-state for pointers, occupancy and the registered head entry.
    always_comb begin
        pop_s           = pop_i && valid_q;
        push_s          = push_i && ((count_q != FIFO_CNT_W'(FIFO_DEPTH)) || pop_s);
        occ_after_pop_s = count_q - FIFO_CNT_W'(pop_s);
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + FIFO_CNT_W'(1);
            2'b01:   count_d = count_q - FIFO_CNT_W'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != FIFO_CNT_W'(0));
        // A word pushed into an (effectively) empty FIFO becomes the head directly.
        if (push_s && (occ_after_pop_s == FIFO_CNT_W'(0))) begin
            head_d = din_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array write; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Control and head registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= FIFO_CNT_W'(0);
            head_q   <= WIDTH'(0);
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign dout_o  = head_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/axis_bram_reader.sv
// axis_bram_reader: streams `length` consecutive BRAM words starting at
// `start_addr` as one AXI-Stream packet. Reads are credit-limited so returning
// data always fits in the output FIFO. Build option AXIS_BRAM_READER_OUTREG_EN
// selects a BRAM read latency of 2 instead of 1.
module axis_bram_reader
    import axis_bram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    input  logic [DATA_WIDTH-1:0] bram_rddata,
    output logic                  bram_clk
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  en_q, en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [RD_LAT-1:0]     vld_q, lst_q;
    logic                  issue_last_s;
    logic                  pop_s;
    logic                  credit_ok_s;
    int                    used_s;
    logic [FIFO_CNT_W-1:0] fifo_count_s;
    logic [DATA_WIDTH:0]   fifo_dout_s;
    logic                  fifo_valid_s;

    // rem_q counts reads still to issue after the one currently on the bus.
    assign issue_last_s = en_q && (rem_q == (ADDR_WIDTH+1)'(0));
    assign pop_s        = fifo_valid_s && m_axis_tready;

    // FSM next-state, read issue and credit accounting.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        en_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // Current read, reads in the latency pipe and FIFO words not leaving this cycle.
        used_s      = int'(en_q) + $countones(vld_q) + int'(fifo_count_s) - int'(pop_s);
        credit_ok_s = (used_s < FIFO_DEPTH);
        case (state_q)
            ST_IDLE: begin
                if (start && (length != (ADDR_WIDTH+1)'(0))) begin
                    state_d = ST_READ;
                    addr_d  = start_addr;
                    rem_d   = length - (ADDR_WIDTH+1)'(1);
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rem_q == (ADDR_WIDTH+1)'(0)) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok_s) begin
                    en_d   = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
                end else begin
                    en_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (pop_s && fifo_dout_s[DATA_WIDTH]) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and read-port registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            addr_q  <= ADDR_WIDTH'(0);
            rem_q   <= (ADDR_WIDTH+1)'(0);
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // In-flight valid/last shift that lines up with BRAM read latency.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q <= RD_LAT'(0);
            lst_q <= RD_LAT'(0);
        end else begin
            vld_q <= (vld_q << 1) | RD_LAT'(en_q);
            lst_q <= (lst_q << 1) | RD_LAT'(issue_last_s);
        end
    end

    axis_bram_reader_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .push_i  (vld_q[RD_LAT-1]),
        .din_i   ({lst_q[RD_LAT-1], bram_rddata}),
        .pop_i   (pop_s),
        .dout_o  (fifo_dout_s),
        .valid_o (fifo_valid_s),
        .count_o (fifo_count_s)
    );

    assign m_axis_tdata  = fifo_dout_s[DATA_WIDTH-1:0];
    assign m_axis_tlast  = fifo_dout_s[DATA_WIDTH];
    assign m_axis_tvalid = fifo_valid_s;
    assign bram_addr     = addr_q;
    assign bram_en       = en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bram_clk      = aclk;

endmodule

// File: tb/tb_axis_bram_reader.sv
// tb_axis_bram_reader: scoreboard bench for axis_bram_reader with a behavioural BRAM
// holding BRAM[a] = a.
module tb_axis_bram_reader;

    localparam int DW = 16;
    localparam int AW = 12;
`ifdef AXIS_BRAM_READER_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [DW-1:0] bram_rddata;
    logic          bram_clk;

    axis_bram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .start_addr(start_addr),
        .length(length), .busy(busy), .done(done), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .bram_addr(bram_addr), .bram_en(bram_en),
        .bram_rddata(bram_rddata), .bram_clk(bram_clk)
    );

    always #5 aclk = ~aclk;

    // Behavioural BRAM: contents equal the address.
    logic [DW-1:0] rd_p1 = '0, rd_p2 = '0;
    always @(posedge aclk) begin
        if (bram_en) rd_p1 <= DW'(bram_addr);
        rd_p2 <= rd_p1;
    end
    assign bram_rddata = (L == 2) ? rd_p2 : rd_p1;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct packed { logic [DW-1:0] data; logic last; } exp_t;
    exp_t exp_q[$];

    int n_tests = 0, n_fail = 0;
    int rdy_mode = 0;
    logic frame_active = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    int reads_issued = 0, beats = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0, t0 = 0;
    int issued_total = 0, popped_total = 0;
    logic expect_done = 1'b0;
    logic hold_valid = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic hold_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver: always high or ~30% duty random.
    initial begin
        forever begin
            @(posedge aclk);
            #2;
            if (rdy_mode == 0) m_axis_tready = 1'b1;
            else m_axis_tready = ($urandom_range(0, 99) < 30);
        end
    end

    // Monitor: scoreboard pops, address sequence, credit bound, stall stability, done.
    initial begin
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                hold_valid = 1'b0;
            end else begin
                if (expect_done) begin
                    check("done_after_last", {30'd0, done, busy}, 32'h2);
                    expect_done = 1'b0;
                end else if (done) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end
                if (done) done_cnt++;
                if (bram_en) begin
                    if (!frame_active) begin
                        check("bram_en_no_frame", 32'd1, 32'd0);
                    end else begin
                        check("bram_addr", 32'(bram_addr), 32'(exp_addr));
                        exp_addr = exp_addr + 12'd1;
                        reads_issued++;
                        check("credit_bound", 32'((issued_total + 1 - popped_total) <= 4), 32'd1);
                    end
                    issued_total++;
                end
                if (hold_valid && m_axis_tvalid) begin
                    check("stall_stable", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, hold_last, hold_data});
                end
                hold_valid = m_axis_tvalid && !m_axis_tready;
                hold_data  = m_axis_tdata;
                hold_last  = m_axis_tlast;
                if (m_axis_tvalid && m_axis_tready) begin
                    popped_total++;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("beat", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, e.last, e.data});
                        if (beats == 0) first_cyc = cyc;
                        beats++;
                        if (e.last) begin
                            last_cyc = cyc;
                            expect_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic launch(input logic [AW-1:0] a, input int len);
        @(negedge aclk);
        exp_addr = a;
        reads_issued = 0;
        beats = 0;
        frame_active = 1'b1;
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.data = DW'(12'(a + 12'(i)));
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
        start = 1'b1;
        start_addr = a;
        length = 13'(len);
        t0 = cyc;
        @(posedge aclk);
        #1;
        check("launch_state", {19'd0, busy, bram_en, bram_addr}, {19'd0, 1'b1, 1'b1, a});
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic finish_frame(input int len, input int d0, input int budget);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge aclk);
            #2;
            k++;
        end
        if (done_cnt == d0) check("frame_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge aclk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("reads_issued", 32'(reads_issued), 32'(len));
        check("one_done", 32'(done_cnt - d0), 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        frame_active = 1'b0;
    endtask

    initial begin
        int d0;
        int k;
        // Reset state.
        repeat (3) @(posedge aclk);
        #1;
        check("reset_outputs", {m_axis_tvalid, m_axis_tlast, bram_en, busy, done, 3'd0, m_axis_tdata, 4'd0, bram_addr},
              32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Basic 4-word frame, back-to-back, latency checks.
        rdy_mode = 0;
        d0 = done_cnt;
        launch(12'h010, 4);
        finish_frame(4, d0, 100);
        check("first_beat_cycle", 32'(first_cyc - t0), 32'(2 + L));
        check("last_beat_cycle", 32'(last_cyc - t0), 32'(1 + L + 4));

        // 64-word frame under random backpressure.
        rdy_mode = 1;
        d0 = done_cnt;
        launch(12'h010, 64);
        finish_frame(64, d0, 3000);

        // Address wrap past the top of the BRAM.
        rdy_mode = 0;
        d0 = done_cnt;
        launch(12'hFFE, 4);
        finish_frame(4, d0, 100);

        // Zero length is ignored.
        d0 = done_cnt;
        @(negedge aclk);
        start = 1'b1;
        start_addr = 12'h055;
        length = 13'd0;
        @(posedge aclk);
        #1;
        check("len0_idle", {30'd0, busy, bram_en}, 32'd0);
        repeat (3) @(negedge aclk);
        start = 1'b0;
        repeat (3) @(negedge aclk);
        check("len0_no_done", 32'(done_cnt - d0), 32'd0);
        check("len0_no_busy", {31'd0, busy}, 32'd0);

        // Start pulsed during READ is ignored.
        rdy_mode = 1;
        d0 = done_cnt;
        launch(12'h100, 16);
        @(negedge aclk);
        start = 1'b1;
        start_addr = 12'h200;
        length = 13'd3;
        @(negedge aclk);
        start = 1'b0;
        finish_frame(16, d0, 1000);

        // Reset mid-frame, then a fresh short frame.
        rdy_mode = 0;
        d0 = done_cnt;
        launch(12'h020, 8);
        k = 0;
        while (beats < 3 && k < 50) begin
            @(posedge aclk);
            #2;
            k++;
        end
        check("beats_before_reset", 32'(beats), 32'd3);
        aresetn = 1'b0;
        #1;
        check("async_reset_clear", {29'd0, m_axis_tvalid, busy, bram_en}, 32'd0);
        exp_q.delete();
        frame_active = 1'b0;
        expect_done = 1'b0;
        issued_total = 0;
        popped_total = 0;
        repeat (3) @(negedge aclk);
        check("reset_no_done", 32'(done_cnt - d0), 32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        d0 = done_cnt;
        launch(12'h030, 2);
        finish_frame(2, d0, 100);

        // Full-BRAM frame with address wrap back to start.
        d0 = done_cnt;
        launch(12'h123, 4096);
        finish_frame(4096, d0, 6000);
        check("full_beats", 32'(beats), 32'd4096);
        check("full_addr_wrap", 32'(exp_addr), 32'h123);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
